sm_step_ctrl: RTL and testbench

SM_STEP_CTRL -- requirements
Module: sm_step_ctrl

---
 rtl/sm_step_pkg.sv | 18 +
 rtl/sm_step_sync.sv | 37 +++
 rtl/sm_step_ctrl.sv | 130 +++++++++++++
 tb/tb_sm_step_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sm_step_pkg.sv
// Shared encodings for the single-step / burst CPU clock controller.
package sm_step_pkg;

    localparam logic [1:0] ModeStop  = 2'b00;
    localparam logic [1:0] ModeRun   = 2'b01;
    localparam logic [1:0] ModeStep  = 2'b10;
    localparam logic [1:0] ModeBurst = 2'b11;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StActive = 2'd2;

    // A burst length of 0 stands for 256 periods.
    function automatic logic [8:0] burst_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/sm_step_sync.sv
// Two-flop synchronizer plus rising-edge detector; emits a one-cycle pulse per input edge.
module sm_step_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] fill_q;
    logic       filled;

    assign filled = (fill_q == 2'd2);

    // Until both sync stages hold real samples, prev tracks the value about to reach s2,
    // so a level already high when reset releases is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= filled ? s2_q : s1_q;
            if (!filled) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/sm_step_ctrl.sv
// CPU clock controller: free-run, single-step and burst modes with a power-of-two divider.
// Optional clkOut rising-edge counter (cycleCnt) is built when SM_STEP_CNT_EN is defined.
module sm_step_ctrl
    import sm_step_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic [3:0]  devide,
    input  logic [1:0]  mode,
    input  logic        stepBtn,
    input  logic [7:0]  burstLen,
    output logic        clkOut,
`ifdef SM_STEP_CNT_EN
    output logic [31:0] cycleCnt,
`endif
    output logic        busy
);

    logic [1:0]       state_q, state_d;
    logic             clk_q, clk_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       div_q, div_d;
    logic [8:0]       rem_q, rem_d;
    logic [CNT_W-1:0] half_lim;
    logic             half_end;
    logic             step_pulse;

    sm_step_sync u_sync (
        .clk   (clkIn),
        .rst_n (rst_n),
        .din   (stepBtn),
        .pulse (step_pulse)
    );

    assign half_lim = (CNT_W'(1) << div_q) - CNT_W'(1);
    assign half_end = (presc_q == half_lim);

    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        presc_d = presc_q;
        div_d   = div_q;
        rem_d   = rem_q;
        case (state_q)
            StIdle: begin
                presc_d = '0;
                clk_d   = 1'b0;
                // A RUN request outranks a simultaneous step edge.
                if (mode == ModeRun) begin
                    state_d = StRun;
                    clk_d   = 1'b1;
                    div_d   = devide;
                end else if (step_pulse && (mode == ModeStep || mode == ModeBurst)) begin
                    state_d = StActive;
                    clk_d   = 1'b1;
                    div_d   = devide;
                    rem_d   = (mode == ModeStep) ? 9'd1 : burst_count(burstLen);
                end
            end
            StRun, StActive: begin
                if (!half_end) begin
                    presc_d = presc_q + CNT_W'(1);
                end else begin
                    presc_d = '0;
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else if (state_q == StRun) begin
                        if (mode != ModeRun) begin
                            state_d = StIdle;
                        end else begin
                            clk_d = 1'b1;
                            div_d = devide;
                        end
                    end else begin
                        rem_d = rem_q - 9'd1;
                        if (rem_q == 9'd1 || mode == ModeStop) begin
                            state_d = StIdle;
                            rem_d   = '0;
                        end else begin
                            clk_d = 1'b1;
                            div_d = devide;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                clk_d   = 1'b0;
                presc_d = '0;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            clk_q   <= 1'b0;
            presc_q <= '0;
            div_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
        end
    end

    assign clkOut = clk_q;
    assign busy   = (state_q != StIdle);

`ifdef SM_STEP_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clk_d && !clk_q) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cycleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Self-checking bench for sm_step_ctrl; expected clkOut waveforms are built period by period.
module tb_sm_step_ctrl;

    localparam logic [1:0] M_STOP  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_STEP  = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    logic        clkIn = 1'b0;
    logic        rst_n;
    logic [3:0]  devide;
    logic [1:0]  mode;
    logic        stepBtn;
    logic [7:0]  burstLen;
    logic        clkOut;
    logic        busy;
`ifdef SM_STEP_CNT_EN
    logic [31:0] cycleCnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_cnt;

    always #5 clkIn = ~clkIn;

    sm_step_ctrl #(.CNT_W(16)) dut (
        .clkIn    (clkIn),
        .rst_n    (rst_n),
        .devide   (devide),
        .mode     (mode),
        .stepBtn  (stepBtn),
        .burstLen (burstLen),
        .clkOut   (clkOut),
`ifdef SM_STEP_CNT_EN
        .cycleCnt (cycleCnt),
`endif
        .busy     (busy)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef SM_STEP_CNT_EN
        n_checks++;
        assert (cycleCnt === model_cnt) else begin
            n_fail++;
            $error("FAIL %s_cnt: observed %0d expected %0d", tag, cycleCnt, model_cnt);
        end
`endif
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // RUN for nper periods; devide switches to d1 at offset chg_off of the first period,
    // mode returns to STOP at offset stop_off of the last one.
    task automatic run_test(input int d0, input int d1, input int nper, input int chg_off,
                            input int stop_off, input bit prearm, input string tag);
        int h;
        devide = 4'(d0);
        if (prearm) begin
            mode    = M_STEP;
            stepBtn = 1'b1;
            tick();
            tick();
            check({tag, "_pre"}, clkOut, 1'b0);
        end
        mode = M_RUN;
        for (int p = 0; p < nper; p++) begin
            h = 1 << ((p == 0) ? d0 : d1);
            for (int i = 0; i < 2 * h; i++) begin
                tick();
                check({tag, "_clk"}, clkOut, (i < h));
                check({tag, "_busy"}, busy, 1'b1);
                if (p == 0 && i == chg_off) devide = 4'(d1);
                if (p == nper - 1 && i == stop_off) mode = M_STOP;
                if (prearm && p == 0 && i == 0) stepBtn = 1'b0;
            end
        end
        tick();
        check({tag, "_end_clk"}, clkOut, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        model_cnt = model_cnt + 32'(nper);
        check_cnt(tag);
        stepBtn = 1'b0;
        repeat (3) tick();
    endtask

    // STEP/BURST launched by a stepBtn edge; optional second press (glitch_at) and
    // optional STOP abort (stop_at) at a sample offset counted from the first clkOut high.
    task automatic active_test(input logic [1:0] m, input int len, input int d,
                               input int glitch_at, input int stop_at, input string tag);
        int h;
        int n;
        int total;
        h = 1 << d;
        n = (m == M_STEP) ? 1 : ((len == 0) ? 256 : len);
        if (stop_at >= 0) n = stop_at / (2 * h) + 1;
        total    = 2 * h * n;
        mode     = m;
        devide   = 4'(d);
        burstLen = 8'(len);
        stepBtn  = 1'b1;
        tick();
        check({tag, "_pre0"}, clkOut, 1'b0);
        tick();
        check({tag, "_pre1"}, clkOut, 1'b0);
        check({tag, "_pre1_busy"}, busy, 1'b0);
        for (int k = 0; k < total; k++) begin
            tick();
            check({tag, "_clk"}, clkOut, ((k % (2 * h)) < h));
            check({tag, "_busy"}, busy, 1'b1);
            if (k == 1) stepBtn = 1'b0;
            if (k == glitch_at) stepBtn = 1'b1;
            if (glitch_at >= 0 && k == glitch_at + 3) stepBtn = 1'b0;
            if (k == stop_at) mode = M_STOP;
        end
        tick();
        check({tag, "_end_clk"}, clkOut, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        model_cnt = model_cnt + 32'(n);
        check_cnt(tag);
        stepBtn = 1'b0;
        repeat (4) tick();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int d;
        int n;
        rst_n     = 1'b0;
        stepBtn   = 1'b0;
        mode      = M_STOP;
        devide    = 4'd0;
        burstLen  = 8'd0;
        model_cnt = 32'd0;
        #2;
        check("reset_clk", clkOut, 1'b0);
        check("reset_busy", busy, 1'b0);
        check_cnt("reset");
        repeat (3) @(posedge clkIn);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check("idle_clk", clkOut, 1'b0);
        check("idle_busy", busy, 1'b0);

        active_test(M_STEP, 0, 2, -1, -1, "step_d2");
        repeat (3) active_test(M_STEP, 0, $urandom_range(0, 3), -1, -1, "step_rnd");

        run_test(0, 0, 5, -1, 0, 1'b0, "run_d0");
        run_test(3, 1, 3, $urandom_range(0, 7), $urandom_range(0, 3), 1'b0, "run_div");
        repeat (3) begin
            d = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            run_test(d, d, n, -1, $urandom_range(0, 2 * (1 << d) - 1), 1'b0, "run_rnd");
        end
        run_test(1, 1, 2, -1, 1, 1'b1, "run_wins");

        active_test(M_BURST, 3, 1, 6, -1, "burst3");
        repeat (2) active_test(M_BURST, $urandom_range(1, 20), $urandom_range(0, 2), -1, -1,
                               "burst_rnd");
        active_test(M_BURST, 10, 1, -1, $urandom_range(0, 19), "burst_stop");
        active_test(M_BURST, 0, 0, -1, -1, "burst256");

        // Reset in the middle of a burst while the button stays pressed.
        mode     = M_BURST;
        burstLen = 8'd20;
        devide   = 4'd1;
        stepBtn  = 1'b1;
        repeat (9) tick();
        check("rst_mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        model_cnt = 32'd0;
        check("rst_mid_clk", clkOut, 1'b0);
        check("rst_mid_busy0", busy, 1'b0);
        check_cnt("rst_mid");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_held_clk", clkOut, 1'b0);
            check("rst_held_busy", busy, 1'b0);
        end
        stepBtn = 1'b0;
        repeat (4) tick();
        active_test(M_BURST, 2, 1, -1, -1, "burst_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
